// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI memory transaction sequencer.
package spi_seq_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    HOLD,
    DONE
  } state_t;

  function automatic logic [7:0] spi_cmd(input logic write);
    return write ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/spi_seq_shifter.sv
// TX shift register (whole command/address/data frame) plus RX data shift register.
module spi_seq_shifter #(
  parameter int N      = 40,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N-1:0]      load_data,
  input  logic              tx_shift,
  input  logic              rx_shift,
  input  logic              miso,
  output logic              tx_msb,
  output logic [DATA_W-1:0] rx_data
);

  logic [N-1:0]      tx_reg;
  logic [DATA_W-1:0] rx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg <= '0;
      rx_reg <= '0;
    end else begin
      // zeros shift in behind the frame, so mosi idles low once it is sent
      if (load) begin
        tx_reg <= load_data;
      end else if (tx_shift) begin
        tx_reg <= {tx_reg[N-2:0], 1'b0};
      end
      if (rx_shift) begin
        rx_reg <= {rx_reg[DATA_W-2:0], miso};
      end
    end
  end

  assign tx_msb  = tx_reg[N-1];
  assign rx_data = rx_reg;

endmodule

// File: rtl/spi_mem_sequencer.sv
// SPI memory read/write sequencer (0x03/0x02 commands, mode 0).
// Define SPI_SEQ_BURST_EN to allow sequential-read continuation in the HOLD cycle.
module spi_mem_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int NCS      = 2,
  parameter int AFIELD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [NCS-1:0]    cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int SEL_W  = $clog2(NCS);
  localparam int SEL_WS = (SEL_W == 0) ? 1 : SEL_W;
  localparam int LOW_W  = ADDR_W - SEL_W;
  localparam int BSH    = $clog2(DATA_W / 8);
  localparam int N      = 8 + AFIELD_W + DATA_W;
  localparam int CNT_W  = $clog2(2 * N);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0] RX_FIRST  = CNT_W'(2 * (8 + AFIELD_W) + 1);
  // Burst resumes as if the last address bit had just finished, giving one
  // extra sclk-low cycle before the first continuation data bit.
  localparam logic [CNT_W-1:0] CNT_BURST = CNT_W'(2 * (8 + AFIELD_W) - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [NCS-1:0]    cs_n_reg, cs_n_next;
  logic              sclk_reg, sclk_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              ready_reg, ready_next;
  logic              write_reg, write_next;

  logic              accept;
  logic              burst_ok;
  logic [SEL_WS-1:0] req_sel;
  logic [NCS-1:0]    cs_sel_n;
  logic [AFIELD_W-1:0] afield;
  logic [DATA_W-1:0] tx_data;
  logic [N-1:0]      frame;
  logic              sh_load, sh_tx_shift, sh_rx_shift;
  logic [DATA_W-1:0] sh_rx_data;

  assign accept = req_valid && ready_reg;

  generate
    if (SEL_W > 0) begin : g_sel
      assign req_sel = req_addr[ADDR_W-1 -: SEL_WS];
    end else begin : g_nosel
      assign req_sel = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NCS; gi++) begin : g_cs
      assign cs_sel_n[gi] = (req_sel != SEL_WS'(gi));
    end
  endgenerate

  assign afield  = AFIELD_W'(req_addr[LOW_W-1:0]) << BSH;
  assign tx_data = req_write ? req_wdata : '0;
  assign frame   = {spi_cmd(req_write), afield, tx_data};

`ifdef SPI_SEQ_BURST_EN
  localparam logic [LOW_W:0] LOW_ONE = {{LOW_W{1'b0}}, 1'b1};
  logic [ADDR_W-1:0] addr_reg;
  logic [LOW_W:0]    low_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (accept) begin
      addr_reg <= req_addr;
    end
  end

  // The extra top bit catches a carry out of the in-chip address bits.
  assign low_inc  = {1'b0, addr_reg[LOW_W-1:0]} + LOW_ONE;
  assign burst_ok = req_valid && !req_write && !write_reg &&
                    ((req_addr >> LOW_W) == (addr_reg >> LOW_W)) &&
                    ({1'b0, req_addr[LOW_W-1:0]} == low_inc);
`else
  assign burst_ok = 1'b0;
`endif

  spi_seq_shifter #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (frame),
    .tx_shift  (sh_tx_shift),
    .rx_shift  (sh_rx_shift),
    .miso      (miso),
    .tx_msb    (mosi),
    .rx_data   (sh_rx_data)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cs_n_next      = cs_n_reg;
    sclk_next      = sclk_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    write_next     = write_reg;
    sh_load        = 1'b0;
    sh_tx_shift    = 1'b0;
    sh_rx_shift    = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        cs_n_next  = '1;
        sclk_next  = 1'b0;
        state_next = IDLE;
        if (accept) begin
          state_next = XFER;
          cnt_next   = '0;
          cs_n_next  = cs_sel_n;
          write_next = req_write;
          sh_load    = 1'b1;
        end
      end
      XFER: begin
        cnt_next = cnt_reg + CNT_ONE;
        if (!cnt_reg[0]) begin
          sclk_next = 1'b1;
        end else begin
          sclk_next   = 1'b0;
          sh_tx_shift = 1'b1;
          sh_rx_shift = !write_reg && (cnt_reg >= RX_FIRST);
          if (cnt_reg == CNT_LAST) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        rsp_valid_next = 1'b1;
        if (!write_reg) begin
          rsp_rdata_next = sh_rx_data;
        end
        if (accept) begin
          state_next = XFER;
          cnt_next   = CNT_BURST;
        end else begin
          state_next = DONE;
          cs_n_next  = '1;
        end
      end
      default: begin
        state_next = IDLE;
        cs_n_next  = '1;
        sclk_next  = 1'b0;
      end
    endcase

    ready_next = (state_next == IDLE) || (state_next == DONE) ||
                 ((state_next == HOLD) && burst_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cs_n_reg      <= '1;
      sclk_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      ready_reg     <= 1'b1;
      write_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cs_n_reg      <= cs_n_next;
      sclk_reg      <= sclk_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      ready_reg     <= ready_next;
      write_reg     <= write_next;
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign cs_n      = cs_n_reg;
  assign sclk      = sclk_reg;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Bench for spi_mem_sequencer at default parameters: cycle-level expectation
// model derived from the frame timing, plus directed literal checks.
module tb_spi_mem_sequencer;

  localparam int N     = 40;
  localparam int DBIT0 = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        miso = 1'b0;
  logic        req_ready, rsp_valid, sclk, mosi;
  logic [15:0] rsp_rdata;
  logic [1:0]  cs_n;

  spi_mem_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expectation model state
  bit          model_en = 1'b1;
  bit          busy = 1'b0;
  int          k = 0;
  logic [N-1:0] m_stream = '0;
  logic [1:0]  m_cs = 2'b11;
  bit          m_read = 1'b0;
  logic [15:0] m_word = '0;
  logic [15:0] m_rdata = '0;
  bit          m_rsp = 1'b0;
  int          n_acc = 0, n_done = 0, acc_cyc = 0, rsp_cyc = 0;

  // observed statistics
  int          rises = 0, tot_rises = 0, done_rises = 0;
  logic [N-1:0] cap = '0, done_cap = '0;
  logic        prev_sclk = 1'b0;
  logic [1:0]  prev_cs = 2'b11, low_cs = 2'b11;
  int          hi_run = 0, last_hi = 0, cs_falls = 0;
  int          rsp_count = 0, rsp_last_cyc = 0, rsp_prev_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // monitor: step the model on the edge just passed, then compare this cycle
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_rsp = 1'b0;
      if (rst) begin
        busy    = 1'b0;
        m_rdata = '0;
      end else if (busy) begin
        k++;
        if (k == 2 * N + 1) begin
          busy       = 1'b0;
          m_rsp      = 1'b1;
          rsp_cyc    = cyc;
          done_rises = rises;
          done_cap   = cap;
          n_done++;
          if (m_read) m_rdata = m_word;
        end
      end else if (req_valid) begin
        busy     = 1'b1;
        k        = 0;
        acc_cyc  = cyc;
        n_acc++;
        m_read   = !req_write;
        m_cs     = req_addr[15] ? 2'b01 : 2'b10;
        m_word   = (req_addr == 16'h8005) ? 16'hBEEF : (req_addr ^ 16'hC3A5);
        m_stream = {(req_write ? 8'h02 : 8'h03), req_addr[14:0], 1'b0,
                    (req_write ? req_wdata : 16'h0000)};
        rises    = 0;
        cap      = '0;
        low_cs   = 2'b11;
      end

      if (sclk && !prev_sclk) begin
        rises++;
        tot_rises++;
        cap = {cap[N-2:0], mosi};
      end
      prev_sclk = sclk;
      if (rsp_valid) begin
        rsp_count++;
        rsp_prev_cyc = rsp_last_cyc;
        rsp_last_cyc = cyc;
      end
      if (cs_n == 2'b11) begin
        hi_run++;
      end else begin
        if (prev_cs == 2'b11) begin
          cs_falls++;
          last_hi = hi_run;
        end
        hi_run = 0;
        low_cs = cs_n;
      end
      prev_cs = cs_n;

      // slave: present read data on the high phase of each data bit
      if (busy && (k % 2 == 1) && (k < 2 * N) && (k / 2 >= DBIT0))
        miso = m_word[15 - (k / 2 - DBIT0)];
      else
        miso = 1'($urandom_range(0, 1));

      if (model_en) begin
        if (busy) begin
          e = {m_cs, 1'(k % 2), 1'b0, 1'b0, 1'b0};
          if (k < 2 * N) e[2] = m_stream[N - 1 - k / 2];
        end else begin
          e = {2'b11, 1'b0, 1'b0, m_rsp, 1'b1};
        end
        check("cs_sclk_mosi_rsp_rdy", {cs_n, sclk, mosi, rsp_valid, req_ready}, e);
        check("rsp_rdata", rsp_rdata, m_rdata);
      end
    end
  end

  task automatic wait_acc(input int start);
    for (int t = 0; t < 400 && n_acc == start; t++) @(negedge clk);
    if (n_acc == start) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cyc=%0d actual=no_accept required=accept", cyc);
    end
  endtask

  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
    int start;
    start = n_acc;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_acc(start);
  endtask

  task automatic wait_done(input int start);
    for (int t = 0; t < 400 && n_done == start; t++) @(negedge clk);
    if (n_done == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout cyc=%0d actual=no_rsp required=rsp", cyc);
    end
  endtask

  initial begin
    int nd, a1, a2, rc, cf, tr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {cs_n, sclk, mosi, rsp_valid, req_ready}, 6'b110001);
    check("reset_rdata", rsp_rdata, 16'h0000);

    // read 0x8005 on chip 1, slave returns 0xBEEF
    nd = n_done;
    send(1'b0, 16'h8005, 16'h0000);
    a1 = acc_cyc;
    req_valid = 1'b0;
    wait_done(nd);
    check("rd_rsp_cycle", rsp_cyc - a1, 81);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rdata", rsp_rdata, 16'hBEEF);
    check("rd_stream", done_cap, 40'h03_000A_0000);
    check("rd_cs", low_cs, 2'b01);
    check("rd_rises", done_rises, 40);

    // write 0x1234 to 0x0003 on chip 0
    nd = n_done;
    send(1'b1, 16'h0003, 16'h1234);
    a1 = acc_cyc;
    req_valid = 1'b0;
    wait_done(nd);
    check("wr_rsp_cycle", rsp_cyc - a1, 81);
    check("wr_stream", done_cap, 40'h02_0006_1234);
    check("wr_cs", low_cs, 2'b10);
    check("wr_rdata_kept", rsp_rdata, 16'hBEEF);

    // reset in cycle 30 of a read
    send(1'b0, 16'h8010, 16'h0000);
    req_valid = 1'b0;
    for (int t = 0; t < 100 && !(busy && k == 30); t++) @(negedge clk);
    rc = rsp_count;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {cs_n, sclk, mosi, rsp_valid, req_ready}, 6'b110001);
    check("midrst_rdata", rsp_rdata, 16'h0000);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_no_rsp", rsp_count - rc, 0);

    // back-to-back with req_valid held; 0x7FFF -> 0x8000 crosses chips
    nd = n_done;
    send(1'b0, 16'h7FFF, 16'h0000);
    a1 = acc_cyc;
    send(1'b0, 16'h8000, 16'h0000);
    a2 = acc_cyc;
    req_valid = 1'b0;
    check("b2b_gap", a2 - a1, 82);
    check("b2b_cs_high", last_hi, 1);
    check("b2b_rises1", done_rises, 40);
    check("b2b_cs2", low_cs, 2'b01);
    wait_done(nd + 1);
    check("b2b_rises2", done_rises, 40);
    check("b2b_rdata2", rsp_rdata, 16'h43A5);

`ifdef SPI_SEQ_BURST_EN
    // sequential read continuation offered in HOLD
    model_en = 1'b0;
    cf = cs_falls;
    tr = tot_rises;
    rc = rsp_count;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h8005;
    @(negedge clk);
    req_addr = 16'h8006;
    for (int t = 0; t < 200 && !req_ready; t++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 0; t < 300 && (rsp_count - rc) < 2; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("burst_cs_falls", cs_falls - cf, 1);
    check("burst_rises", tot_rises - tr, 56);
    check("burst_rsp_count", rsp_count - rc, 2);
    check("burst_rsp_gap", rsp_last_cyc - rsp_prev_cyc, 34);
`else
    // sequential addresses still run as two full transfers
    nd = n_done;
    send(1'b0, 16'h8005, 16'h0000);
    a1 = acc_cyc;
    send(1'b0, 16'h8006, 16'h0000);
    a2 = acc_cyc;
    req_valid = 1'b0;
    check("seq_gap", a2 - a1, 82);
    wait_done(nd + 1);
    check("seq_rises2", done_rises, 40);
    check("seq_stream2", done_cap, 40'h03_000C_0000);
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
